// File: rtl/regfile_fetch_ctrl_if.sv
// Bus bundle between the operand-fetch sequencer, decode, execute writeback and the 1R/1W register file.
// master: the surrounding pipeline and regfile; slave: the fetch sequencer.
interface regfile_fetch_ctrl_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_ra;
    logic [ADDR_WIDTH-1:0] req_rb;
    logic                  req_nb;

    logic                  op_valid;
    logic                  op_ready;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;

    logic                  wb_we;
    logic [ADDR_WIDTH-1:0] wb_adr;
    logic [DATA_WIDTH-1:0] wb_data;

    logic                  rf_we;
    logic [ADDR_WIDTH-1:0] rf_wadr;
    logic [DATA_WIDTH-1:0] rf_din;
    logic [ADDR_WIDTH-1:0] rf_radr1;
    logic [DATA_WIDTH-1:0] rf_dout1;

    modport master (
        output req_valid, req_ra, req_rb, req_nb, op_ready,
        output wb_we, wb_adr, wb_data, rf_dout1,
        input  req_ready, op_valid, op_a, op_b,
        input  rf_we, rf_wadr, rf_din, rf_radr1
    );

    modport slave (
        input  req_valid, req_ra, req_rb, req_nb, op_ready,
        input  wb_we, wb_adr, wb_data, rf_dout1,
        output req_ready, op_valid, op_a, op_b,
        output rf_we, rf_wadr, rf_din, rf_radr1
    );
endinterface

// File: rtl/regfile_fetch_ctrl.sv
// Operand-fetch sequencer: serialises up to two source reads onto the single regfile read port,
// owns the write port, and keeps returned operands coherent with in-flight writebacks.
//
// state  | meaning
// IDLE   | ready for a decode request, read port parked at 0
// RD_A   | read port presents source A
// RD_B   | read port presents source B, op_a captured from regfile
// WAIT_B | op_b captured from regfile
// WAIT_A | single-operand request: op_a captured, op_b cleared
// DONE   | operands valid, waiting for consumer handshake
module regfile_fetch_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter bit R0_ZERO    = 1'b1
) (
    input  logic clk,
    input  logic reset,
    regfile_fetch_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_A   = 3'd1,
        RD_B   = 3'd2,
        WAIT_B = 3'd3,
        WAIT_A = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t                state;
    state_t                state_nxt;

    logic [ADDR_WIDTH-1:0] ra_q;
    logic [ADDR_WIDTH-1:0] rb_q;
    logic                  nb_q;
    logic [DATA_WIDTH-1:0] op_a_q;
    logic [DATA_WIDTH-1:0] op_b_q;
    logic                  fwd_a_q;
    logic                  fwd_b_q;

    logic                  accept;
    logic                  wr_en;
    logic                  win_b;
    logic                  hit_a;
    logic                  hit_b;
    logic                  zero_a;
    logic                  zero_b;

    // Writeback pass-through is independent of the sequencer state.
    assign wr_en        = bus.wb_we & ~(R0_ZERO & (bus.wb_adr == '0));
    assign bus.rf_we    = wr_en;
    assign bus.rf_wadr  = bus.wb_adr;
    assign bus.rf_din   = bus.wb_data;

    // Gated by reset so the port reads not-ready while reset is held.
    assign bus.req_ready = (state == IDLE) & reset;
    assign accept        = (state == IDLE) & bus.req_valid;

    assign bus.op_valid = (state == DONE);
    assign bus.op_a     = op_a_q;
    assign bus.op_b     = op_b_q;

    // Forward windows open at the edge where the regfile samples each operand address.
    assign win_b  = nb_q & ((state == RD_B) | (state == WAIT_B) | (state == DONE));
    assign hit_a  = wr_en & (bus.wb_adr == ra_q) & (state != IDLE);
    assign hit_b  = wr_en & (bus.wb_adr == rb_q) & win_b;
    assign zero_a = R0_ZERO & (ra_q == '0);
    assign zero_b = R0_ZERO & (rb_q == '0);

    always_comb begin
        bus.rf_radr1 = '0;
        case (state)
            RD_A:    bus.rf_radr1 = ra_q;
            RD_B:    bus.rf_radr1 = rb_q;
            default: bus.rf_radr1 = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RD_A;
            RD_A:    state_nxt = nb_q ? RD_B : WAIT_A;
            RD_B:    state_nxt = WAIT_B;
            WAIT_B:  state_nxt = DONE;
            WAIT_A:  state_nxt = DONE;
            DONE:    if (bus.op_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ra_q <= '0;
            rb_q <= '0;
            nb_q <= 1'b0;
        end else if (accept) begin
            ra_q <= bus.req_ra;
            rb_q <= bus.req_rb;
            nb_q <= bus.req_nb;
        end
    end

    // fwd_*_q marks that a write landed on or after the sampling edge, so the
    // (possibly stale) regfile read data must not overwrite the forwarded value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_a_q  <= '0;
            fwd_a_q <= 1'b0;
        end else if (accept) begin
            fwd_a_q <= 1'b0;
        end else if ((state == RD_B) || (state == WAIT_A)) begin
            if (zero_a) begin
                op_a_q <= '0;
            end else if (hit_a) begin
                op_a_q <= bus.wb_data;
            end else if (!fwd_a_q) begin
                op_a_q <= bus.rf_dout1;
            end
        end else if (hit_a) begin
            op_a_q  <= bus.wb_data;
            fwd_a_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_b_q  <= '0;
            fwd_b_q <= 1'b0;
        end else if (accept) begin
            fwd_b_q <= 1'b0;
        end else if (state == WAIT_A) begin
            op_b_q <= '0;
        end else if (state == WAIT_B) begin
            if (zero_b) begin
                op_b_q <= '0;
            end else if (hit_b) begin
                op_b_q <= bus.wb_data;
            end else if (!fwd_b_q) begin
                op_b_q <= bus.rf_dout1;
            end
        end else if (hit_b) begin
            op_b_q  <= bus.wb_data;
            fwd_b_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_fetch_ctrl.sv
// Self-checking bench for regfile_fetch_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a register-contents reference model.
module tb_regfile_fetch_ctrl;
    localparam int AW = 4;
    localparam int DW = 16;
    localparam int NREG = 2 ** AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_fetch_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    regfile_fetch_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .R0_ZERO(1'b1)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    logic [DW-1:0] rf_mem  [NREG];
    logic [DW-1:0] ref_mem [NREG];

    int n_vec = 0;
    int n_err = 0;

    bit            m_busy = 1'b0;
    int            m_cnt = 0;
    int            m_lat = 0;
    logic [AW-1:0] m_ra = '0;
    logic [AW-1:0] m_rb = '0;
    logic          m_nb = 1'b0;
    bit            m_ev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural register value as seen through the fetch port.
    function automatic logic [DW-1:0] ref_val(input logic [AW-1:0] a);
        return (a == '0) ? '0 : ref_mem[a];
    endfunction

    function automatic logic [AW-1:0] pick_adr();
        logic [31:0] r;
        r = $urandom;
        return r[0] ? AW'(r[9:8]) : AW'(r[7:4]);
    endfunction

    // Regfile: synchronous read with read-before-write on a same-edge collision.
    always @(posedge clk) begin
        bus.rf_dout1 <= rf_mem[bus.rf_radr1];
        if (bus.rf_we) rf_mem[bus.rf_wadr] = bus.rf_din;
    end

    always @(posedge clk) begin
        if (bus.wb_we && (bus.wb_adr != '0)) ref_mem[bus.wb_adr] = bus.wb_data;
    end

    // Request timeline: cycles since acceptance; operands due after 3 (two-op) or 2 (one-op).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_cnt  = 0;
        end else if (!m_busy) begin
            if (bus.req_valid) begin
                m_busy = 1'b1;
                m_cnt  = 0;
                m_ra   = bus.req_ra;
                m_rb   = bus.req_rb;
                m_nb   = bus.req_nb;
                m_lat  = bus.req_nb ? 3 : 2;
            end
        end else if (m_cnt >= m_lat) begin
            if (bus.op_ready) m_busy = 1'b0;
        end else begin
            m_cnt++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            m_ev = m_busy && (m_cnt >= m_lat);
            chk("req_ready", 32'(bus.req_ready), 32'(!m_busy));
            chk("op_valid", 32'(bus.op_valid), 32'(m_ev));
            if (m_ev) begin
                chk("op_a", 32'(bus.op_a), 32'(ref_val(m_ra)));
                chk("op_b", 32'(bus.op_b), m_nb ? 32'(ref_val(m_rb)) : 32'd0);
            end
            chk("rf_we", 32'(bus.rf_we), 32'(bus.wb_we && (bus.wb_adr != '0)));
            chk("rf_wadr", 32'(bus.rf_wadr), 32'(bus.wb_adr));
            chk("rf_din", 32'(bus.rf_din), 32'(bus.wb_data));
            if (!m_busy)
                chk("rf_radr1_idle", 32'(bus.rf_radr1), 32'd0);
            else if (m_cnt == 0)
                chk("rf_radr1_a", 32'(bus.rf_radr1), 32'(m_ra));
            else if ((m_cnt == 1) && m_nb)
                chk("rf_radr1_b", 32'(bus.rf_radr1), 32'(m_rb));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.wb_we   = 1'b1;
        bus.wb_adr  = a;
        bus.wb_data = d;
        tick();
        bus.wb_we = 1'b0;
    endtask

    // Presents a request for one edge; returns 1ns after the accept edge.
    task automatic issue(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic nb);
        bus.req_valid = 1'b1;
        bus.req_ra    = a;
        bus.req_rb    = b;
        bus.req_nb    = nb;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic handshake();
        bus.op_ready = 1'b1;
        tick();
        bus.op_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) begin
            rf_mem[i]  = DW'($urandom);
            ref_mem[i] = rf_mem[i];
        end
        rf_mem[0] = 16'hDEAD;
        bus.req_valid = 1'b0;
        bus.req_ra    = '0;
        bus.req_rb    = '0;
        bus.req_nb    = 1'b0;
        bus.op_ready  = 1'b0;
        bus.wb_we     = 1'b0;
        bus.wb_adr    = '0;
        bus.wb_data   = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_op_valid", 32'(bus.op_valid), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_op_a", 32'(bus.op_a), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_req_ready", 32'(bus.req_ready), 32'd1);
        tick();

        // Two-operand fetch latency and data.
        wb_write(4'd3, 16'h1234);
        wb_write(4'd5, 16'hBEEF);
        issue(4'd3, 4'd5, 1'b1);
        tick();
        tick();
        chk("t2_early_valid", 32'(bus.op_valid), 32'd0);
        tick();
        chk("t2_valid", 32'(bus.op_valid), 32'd1);
        chk("t2_op_a", 32'(bus.op_a), 32'h1234);
        chk("t2_op_b", 32'(bus.op_b), 32'hBEEF);
        handshake();

        // Write to B on its sampling edge must be forwarded.
        issue(4'd3, 4'd5, 1'b1);
        tick();
        bus.wb_we   = 1'b1;
        bus.wb_adr  = 4'd5;
        bus.wb_data = 16'h5555;
        tick();
        bus.wb_we = 1'b0;
        tick();
        chk("t4_valid", 32'(bus.op_valid), 32'd1);
        chk("t4_op_a", 32'(bus.op_a), 32'h1234);
        chk("t4_op_b", 32'(bus.op_b), 32'h5555);
        handshake();

        // One-operand fetch.
        wb_write(4'd7, 16'h00AA);
        issue(4'd7, 4'd9, 1'b0);
        tick();
        chk("t3_early_valid", 32'(bus.op_valid), 32'd0);
        tick();
        chk("t3_valid", 32'(bus.op_valid), 32'd1);
        chk("t3_op_a", 32'(bus.op_a), 32'h00AA);
        chk("t3_op_b", 32'(bus.op_b), 32'd0);
        handshake();

        // R0 is never written and always reads as zero.
        bus.wb_we   = 1'b1;
        bus.wb_adr  = 4'd0;
        bus.wb_data = 16'hFFFF;
        #1;
        chk("t5_rf_we", 32'(bus.rf_we), 32'd0);
        tick();
        bus.wb_we = 1'b0;
        issue(4'd0, 4'd0, 1'b1);
        repeat (3) tick();
        chk("t5_valid", 32'(bus.op_valid), 32'd1);
        chk("t5_op_a", 32'(bus.op_a), 32'd0);
        chk("t5_op_b", 32'(bus.op_b), 32'd0);
        handshake();

        // Operands track writes while the consumer stalls.
        issue(4'd3, 4'd5, 1'b1);
        repeat (3) tick();
        bus.wb_we   = 1'b1;
        bus.wb_adr  = 4'd3;
        bus.wb_data = 16'h9999;
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.wb_we = 1'b0;
            chk("t6_valid_hold", 32'(bus.op_valid), 32'd1);
            chk("t6_ready_low", 32'(bus.req_ready), 32'd0);
        end
        chk("t6_op_a", 32'(bus.op_a), 32'h9999);
        chk("t6_op_b", 32'(bus.op_b), 32'h5555);
        handshake();
        chk("t6_ready_back", 32'(bus.req_ready), 32'd1);
        chk("t6_valid_drop", 32'(bus.op_valid), 32'd0);

        // Reset in the middle of RD_B abandons the request.
        issue(4'd3, 4'd5, 1'b1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_op_valid", 32'(bus.op_valid), 32'd0);
        chk("t1_op_a", 32'(bus.op_a), 32'd0);
        chk("t1_op_b", 32'(bus.op_b), 32'd0);
        chk("t1_req_ready", 32'(bus.req_ready), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("t1_rel_ready", 32'(bus.req_ready), 32'd1);
        tick();

        // Randomized traffic, address-biased toward collisions, with one reset pulse.
        for (int c = 0; c < 4000; c++) begin
            bus.req_valid = 1'($urandom_range(0, 1));
            bus.req_ra    = pick_adr();
            bus.req_rb    = pick_adr();
            bus.req_nb    = 1'($urandom_range(0, 1));
            bus.op_ready  = ($urandom_range(0, 9) < 6);
            bus.wb_we     = ($urandom_range(0, 9) < 4);
            bus.wb_adr    = pick_adr();
            bus.wb_data   = DW'($urandom);
            if (c == 2000) begin
                #2;
                rst_n = 1'b0;
            end
            if (c == 2003) rst_n = 1'b1;
            tick();
        end

        bus.req_valid = 1'b0;
        bus.op_ready  = 1'b1;
        bus.wb_we     = 1'b0;
        repeat (6) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
